// File: rtl/fp_normalize.sv
// fp_normalize: two-stage post-add normalizer packing an IEEE-754 single with zero/ovf/unf flags
module fp_normalize (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [24:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_unf
);
  logic        s1_valid, s1_sign;
  logic [7:0]  s1_exp;
  logic [24:0] s1_mant;
  logic [4:0]  s1_lz, lz;
  logic        s2_free, s1_adv, accept;
  logic        is_zero, is_inf, is_unf;
  logic [8:0]  e_inc, e_dec;
  logic [22:0] shl;
  logic [31:0] res;
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = rst_n && (!s1_valid || s2_free);
  assign accept   = in_valid && in_ready;
  // last hit from the LSB upward is the highest set bit
  always_comb begin
    lz = 5'd24;
    for (int i = 0; i < 24; i++)
      if (in_mant[i]) lz = 5'(23 - i);
  end
  always_comb begin
    e_inc   = {1'b0, s1_exp} + 9'd1;
    e_dec   = {1'b0, s1_exp} - {4'b0, s1_lz};
    shl     = 23'(s1_mant[23:0] << s1_lz);
    is_zero = s1_mant == 25'd0;
    is_inf  = !is_zero && (s1_exp == 8'hff || (s1_mant[24] && e_inc == 9'd255));
    is_unf  = !is_zero && !is_inf && !s1_mant[24] && ({1'b0, s1_exp} <= {4'b0, s1_lz});
    res     = (is_zero || is_unf) ? {s1_sign, 31'b0} :
              is_inf              ? {s1_sign, 8'hff, 23'b0} :
              s1_mant[24]         ? {s1_sign, e_inc[7:0], s1_mant[23:1]} :
                                    {s1_sign, e_dec[7:0], shl};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_sign  <= in_sign;
      s1_exp   <= in_exp;
      s1_mant  <= in_mant;
      s1_lz    <= lz;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= 32'h0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_unf    <= 1'b0;
    end else if (s1_adv) begin
      out_valid  <= 1'b1;
      out_result <= res;
      out_zero   <= is_zero;
      out_ovf    <= is_inf;
      out_unf    <= is_unf;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: directed vectors, backpressure stream and mid-stream reset for fp_normalize
module tb_fp_normalize;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_sign = 0, out_ready = 1;
  logic [7:0]  in_exp = 0;
  logic [24:0] in_mant = 0;
  logic        in_ready, out_valid, out_zero, out_ovf, out_unf;
  logic [31:0] out_result;
  int checks = 0, errors = 0;

  fp_normalize dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [24:0] m;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v[14];
    logic [31:0] q[$];
    logic [31:0] held;
    logic stall_prev;
    int nw, rcv;
    // flag field is {zero, ovf, unf}
    v[0]  = '{1'b0, 8'd127, 25'h0800000, 32'h3F800000, 3'b000};
    v[1]  = '{1'b0, 8'd127, 25'h1800000, 32'h40400000, 3'b000};
    v[2]  = '{1'b0, 8'd254, 25'h1000000, 32'h7F800000, 3'b010};
    v[3]  = '{1'b0, 8'd130, 25'h0000001, 32'h35800000, 3'b000};
    v[4]  = '{1'b1, 8'd23,  25'h0000001, 32'h80000000, 3'b001};
    v[5]  = '{1'b1, 8'd90,  25'h0000000, 32'h80000000, 3'b100};
    v[6]  = '{1'b0, 8'd255, 25'h0800000, 32'h7F800000, 3'b010};
    v[7]  = '{1'b0, 8'd255, 25'h0000000, 32'h00000000, 3'b100};
    v[8]  = '{1'b0, 8'd24,  25'h0000001, 32'h00800000, 3'b000};
    v[9]  = '{1'b0, 8'd253, 25'h1000000, 32'h7F000000, 3'b000};
    v[10] = '{1'b1, 8'd100, 25'h0123456, 32'hB091A2B0, 3'b000};
    v[11] = '{1'b0, 8'd0,   25'h1FFFFFF, 32'h00FFFFFF, 3'b000};
    v[12] = '{1'b0, 8'd0,   25'h0800000, 32'h00000000, 3'b001};
    v[13] = '{1'b1, 8'd1,   25'h0800000, 32'h80800000, 3'b000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_result", out_result, 32'h0);
    chk("reset_flags", {29'b0, out_zero, out_ovf, out_unf}, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1;
    #1 chk("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    foreach (v[i]) begin
      in_valid = 1; in_sign = v[i].s; in_exp = v[i].e; in_mant = v[i].m;
      #1 chk($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(posedge clk); @(negedge clk);
      in_valid = 0;
      chk($sformatf("vec%0d_early_valid", i), {31'b0, out_valid}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_result", i), out_result, v[i].r);
      chk($sformatf("vec%0d_flags", i), {29'b0, out_zero, out_ovf, out_unf}, {29'b0, v[i].f});
    end
    @(negedge clk);

    // six words back to back, downstream stalls in cycles 3..5
    nw = 0; rcv = 0; stall_prev = 0; held = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = nw < 6;
      in_sign = 0; in_exp = 8'(100 + nw); in_mant = 25'h0800000;
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc >= 3 && cyc <= 5) chk($sformatf("bp_in_ready_c%0d", cyc), {31'b0, in_ready}, 32'd0);
      if (stall_prev) begin
        chk($sformatf("bp_hold_valid_c%0d", cyc), {31'b0, out_valid}, 32'd1);
        chk($sformatf("bp_hold_result_c%0d", cyc), out_result, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("bp_extra_word", out_result, 32'hFFFFFFFF);
        else chk($sformatf("bp_word%0d", rcv), out_result, q.pop_front());
        rcv++;
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, 8'(100 + nw), 23'b0});
        nw++;
      end
      stall_prev = out_valid && !out_ready;
      held = out_result;
      if (rcv == 6) break;
      @(negedge clk);
    end
    in_valid = 0;
    chk("bp_received", rcv, 32'd6);
    chk("bp_queue_empty", q.size(), 32'd0);
    @(negedge clk);
    #1 chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // fill both stages, then reset
    out_ready = 0;
    in_valid = 1; in_exp = 8'd50; in_mant = 25'h0800000;
    @(posedge clk); @(negedge clk);
    in_exp = 8'd51;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("rs_full_valid", {31'b0, out_valid}, 32'd1);
    chk("rs_full_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 0;
    @(posedge clk); @(negedge clk);
    chk("rs_valid", {31'b0, out_valid}, 32'd0);
    chk("rs_result", out_result, 32'h0);
    chk("rs_flags", {29'b0, out_zero, out_ovf, out_unf}, 32'd0);
    chk("rs_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1; out_ready = 1;
    #1 chk("rs_in_ready_release", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rs_no_stale_%0d", k), {31'b0, out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
